// File: rtl/mops_data_generator.sv
// Emulates the MOPS front-end chips behind up to 32 CAN buses for hub system test.
// It produces the divided MOPS clock, oscillator-trim handshakes and RX/TX/advanced test frames.
module mops_data_generator #(
  parameter int DIV_RATIO   = 4,
  parameter int N_ADC_CH    = 36,
  parameter int FRAME_GAP   = 16,
  parameter int TRIM_CYCLES = 64,
  parameter int TX_TIMEOUT  = 1024
) (
  input  logic        clk_40_m,
  input  logic        rst,
  input  logic [4:0]  n_buses,
  input  logic        ext_trim_mops,
  input  logic        start_trim_osc,
  input  logic        test_rx,
  input  logic        test_tx,
  input  logic        test_advanced,
  input  logic        tra_valid,
  input  logic [4:0]  can_tra_select,
  output logic        clk_mops,
  output logic        ready_osc,
  output logic        end_trim_bus,
  output logic        test_rx_start,
  output logic        test_rx_end,
  output logic        test_tx_start,
  output logic        test_tx_end,
  output logic        test_advanced_end,
  output logic [7:0]  bus_id,
  output logic [5:0]  adc_ch,
  output logic [75:0] bus_dec_data,
  output logic        frame_valid,
  output logic        tx_err
);
  localparam int HALF_DIV = DIV_RATIO / 2;
  localparam int DIV_W    = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int CNT_MAX  = (TX_TIMEOUT > TRIM_CYCLES) ?
                            ((TX_TIMEOUT > FRAME_GAP) ? TX_TIMEOUT : FRAME_GAP) :
                            ((TRIM_CYCLES > FRAME_GAP) ? TRIM_CYCLES : FRAME_GAP);
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam logic [7:0] CMD_RX = 8'h43;
  localparam logic [7:0] CMD_TX = 8'h60;

  typedef enum logic [3:0] {
    S_IDLE, S_TRIM, S_RX_START, S_RX_RUN, S_RX_END,
    S_TX_START, S_TX_WAIT, S_TX_END, S_ADV_END
  } state_t;

  typedef struct packed {
    logic ready_osc;
    logic end_trim_bus;
    logic rx_start;
    logic rx_end;
    logic tx_start;
    logic tx_end;
    logic adv_end;
    logic frame_valid;
  } pulse_t;

  function automatic logic [75:0] build_frame(input logic [4:0] bus, input logic [5:0] ch,
                                              input logic [7:0] cmd);
    return {bus, 11'h581, 4'h8, cmd, 16'h2400, 2'b00, ch, 12'h000, bus[3:0], ch, 2'b00};
  endfunction

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_clk_mops;

  // NOTE: sequential state always uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_40_m) begin
    if (!rst) begin
      r_div_cnt  <= '0;
      r_clk_mops <= 1'b0;
    end else if (r_div_cnt == DIV_W'(HALF_DIV - 1)) begin
      r_div_cnt  <= '0;
      r_clk_mops <= ~r_clk_mops;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  state_t           r_state,  w_state_nxt;
  logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
  logic [4:0]       r_bus,    w_bus_nxt;
  logic [5:0]       r_ch,     w_ch_nxt;
  logic [4:0]       r_nbus,   w_nbus_nxt;
  logic             r_adv,    w_adv_nxt;
  logic [75:0]      r_frame,  w_frame_nxt;
  logic             r_tx_err, w_tx_err_nxt;
  pulse_t           r_pulse,  w_pulse_nxt;

  logic w_tx_match;
  logic w_tx_timeout;
  assign w_tx_match   = tra_valid && (can_tra_select == r_bus);
  assign w_tx_timeout = (r_cnt == CNT_W'(TX_TIMEOUT - 1));

  // Outputs are registered from the next-state decision, so each pulse is high
  // during exactly the cycle the FSM spends in the state that owns it.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_bus_nxt    = r_bus;
    w_ch_nxt     = r_ch;
    w_nbus_nxt   = r_nbus;
    w_adv_nxt    = r_adv;
    w_frame_nxt  = r_frame;
    w_tx_err_nxt = r_tx_err;
    w_pulse_nxt  = '0;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (ext_trim_mops && start_trim_osc) begin
          w_state_nxt = S_TRIM;
        end else if (test_advanced || test_rx) begin
          w_state_nxt          = S_RX_START;
          w_adv_nxt            = test_advanced;
          w_nbus_nxt           = n_buses;
          w_bus_nxt            = '0;
          w_ch_nxt             = '0;
          w_pulse_nxt.rx_start = 1'b1;
        end else if (test_tx) begin
          w_state_nxt          = S_TX_START;
          w_adv_nxt            = 1'b0;
          w_nbus_nxt           = n_buses;
          w_bus_nxt            = '0;
          w_ch_nxt             = '0;
          w_pulse_nxt.tx_start = 1'b1;
        end
      end
      S_TRIM: begin
        if (r_cnt == CNT_W'(TRIM_CYCLES - 1)) begin
          w_state_nxt              = S_IDLE;
          w_cnt_nxt                = '0;
          w_pulse_nxt.ready_osc    = 1'b1;
          w_pulse_nxt.end_trim_bus = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_RX_START: begin
        w_state_nxt             = S_RX_RUN;
        w_cnt_nxt               = '0;
        w_frame_nxt             = build_frame(r_bus, r_ch, CMD_RX);
        w_pulse_nxt.frame_valid = 1'b1;
      end
      S_RX_RUN: begin
        if (r_cnt == CNT_W'(FRAME_GAP - 1)) begin
          w_cnt_nxt = '0;
          if (r_bus == r_nbus && r_ch == 6'(N_ADC_CH - 1)) begin
            w_state_nxt        = S_RX_END;
            w_pulse_nxt.rx_end = 1'b1;
          end else begin
            if (r_ch == 6'(N_ADC_CH - 1)) begin
              w_ch_nxt  = '0;
              w_bus_nxt = r_bus + 1'b1;
            end else begin
              w_ch_nxt = r_ch + 1'b1;
            end
            w_frame_nxt             = build_frame(w_bus_nxt, w_ch_nxt, CMD_RX);
            w_pulse_nxt.frame_valid = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_RX_END: begin
        if (r_adv) begin
          w_state_nxt          = S_TX_START;
          w_bus_nxt            = '0;
          w_ch_nxt             = '0;
          w_pulse_nxt.tx_start = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_TX_START: begin
        w_state_nxt = S_TX_WAIT;
        w_cnt_nxt   = '0;
      end
      S_TX_WAIT: begin
        if (w_tx_match || w_tx_timeout) begin
          w_cnt_nxt = '0;
          if (w_tx_match) begin
            w_frame_nxt             = build_frame(r_bus, 6'd0, CMD_TX);
            w_pulse_nxt.frame_valid = 1'b1;
          end else begin
            w_tx_err_nxt = 1'b1;
          end
          if (r_bus == r_nbus) begin
            w_state_nxt        = S_TX_END;
            w_pulse_nxt.tx_end = 1'b1;
          end else begin
            w_state_nxt          = S_TX_START;
            w_bus_nxt            = r_bus + 1'b1;
            w_pulse_nxt.tx_start = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_TX_END: begin
        if (r_adv) begin
          w_state_nxt         = S_ADV_END;
          w_pulse_nxt.adv_end = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ADV_END: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_40_m) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_bus    <= '0;
      r_ch     <= '0;
      r_nbus   <= '0;
      r_adv    <= 1'b0;
      r_frame  <= '0;
      r_tx_err <= 1'b0;
      r_pulse  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_bus    <= w_bus_nxt;
      r_ch     <= w_ch_nxt;
      r_nbus   <= w_nbus_nxt;
      r_adv    <= w_adv_nxt;
      r_frame  <= w_frame_nxt;
      r_tx_err <= w_tx_err_nxt;
      r_pulse  <= w_pulse_nxt;
    end
  end

  assign clk_mops          = r_clk_mops;
  assign ready_osc         = r_pulse.ready_osc;
  assign end_trim_bus      = r_pulse.end_trim_bus;
  assign test_rx_start     = r_pulse.rx_start;
  assign test_rx_end       = r_pulse.rx_end;
  assign test_tx_start     = r_pulse.tx_start;
  assign test_tx_end       = r_pulse.tx_end;
  assign test_advanced_end = r_pulse.adv_end;
  assign frame_valid       = r_pulse.frame_valid;
  assign bus_id            = {3'b000, r_bus};
  assign adc_ch            = r_ch;
  assign bus_dec_data      = r_frame;
  assign tx_err            = r_tx_err;

endmodule

// File: tb/tb_mops_data_generator.sv
// Directed bench for mops_data_generator: reset, divider, trim, RX, TX, advanced and
// mid-phase reset, with hand-computed expected frames and pulse timing.
`timescale 1ns/1ps
module tb_mops_data_generator;
  logic        clk_40_m = 1'b0;
  logic        rst;
  logic [4:0]  n_buses;
  logic        ext_trim_mops, start_trim_osc;
  logic        test_rx, test_tx, test_advanced;
  logic        tra_valid;
  logic [4:0]  can_tra_select;
  logic        clk_mops, ready_osc, end_trim_bus;
  logic        test_rx_start, test_rx_end, test_tx_start, test_tx_end, test_advanced_end;
  logic [7:0]  bus_id;
  logic [5:0]  adc_ch;
  logic [75:0] bus_dec_data;
  logic        frame_valid, tx_err;

  mops_data_generator dut (
    .clk_40_m(clk_40_m), .rst(rst), .n_buses(n_buses),
    .ext_trim_mops(ext_trim_mops), .start_trim_osc(start_trim_osc),
    .test_rx(test_rx), .test_tx(test_tx), .test_advanced(test_advanced),
    .tra_valid(tra_valid), .can_tra_select(can_tra_select),
    .clk_mops(clk_mops), .ready_osc(ready_osc), .end_trim_bus(end_trim_bus),
    .test_rx_start(test_rx_start), .test_rx_end(test_rx_end),
    .test_tx_start(test_tx_start), .test_tx_end(test_tx_end),
    .test_advanced_end(test_advanced_end), .bus_id(bus_id), .adc_ch(adc_ch),
    .bus_dec_data(bus_dec_data), .frame_valid(frame_valid), .tx_err(tx_err)
  );

  always #5 clk_40_m = ~clk_40_m;

  int n_checks = 0;
  int n_pass   = 0;
  int hub_cd   = -1;
  logic [4:0] hub_sel = '0;

  task automatic check(input string tag, input logic [75:0] got, input logic [75:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk_40_m);
    #1;
  endtask

  // Hub model: answers each test_tx_start two cycles later; bus 1 gets a wrong select.
  task automatic hub_step();
    tra_valid = 1'b0;
    if (test_tx_start) begin
      hub_sel = (bus_id == 8'd1) ? 5'd3 : bus_id[4:0];
      hub_cd  = 2;
    end else if (hub_cd > 0) begin
      hub_cd--;
    end
    if (hub_cd == 0) begin
      tra_valid      = 1'b1;
      can_tra_select = hub_sel;
      hub_cd         = -1;
    end
  endtask

  function automatic logic [8:0] pulses();
    return {ready_osc, end_trim_bus, test_rx_start, test_rx_end, test_tx_start,
            test_tx_end, test_advanced_end, frame_valid, tx_err};
  endfunction

  logic [75:0] first_frame, last_frame, tx_frame0, tx_frame1;
  logic [7:0]  clk_pat;
  logic [8:0]  pulse_or;
  int frames, bad_gaps, last_t, first_t, cnt_a, cnt_b, t_a, t_b, t_c, t_d, tx_frames, mism;
  bit done;

  initial begin
    rst = 1'b0; n_buses = '0; ext_trim_mops = 0; start_trim_osc = 0;
    test_rx = 0; test_tx = 0; test_advanced = 0; tra_valid = 0; can_tra_select = '0;
    repeat (3) tick();
    check("rst_pulses", 76'(pulses()), 76'd0);
    check("rst_clk_mops", 76'(clk_mops), 76'd0);
    check("rst_frame", bus_dec_data, 76'd0);
    check("rst_bus_ch", 76'({bus_id, adc_ch}), 76'd0);

    // Divider: period 4, first rising edge two cycles after release.
    rst = 1'b1;
    pulse_or = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      clk_pat[7-i] = clk_mops;
      pulse_or |= pulses();
    end
    check("clk_mops_pattern", 76'(clk_pat), 76'(8'b0110_0110));
    check("idle_pulses", 76'(pulse_or), 76'd0);

    // Trim handshake.
    ext_trim_mops = 1; start_trim_osc = 1;
    cnt_a = 0; cnt_b = 0; first_t = 0; mism = 0;
    for (int t = 1; t <= 100; t++) begin
      tick();
      ext_trim_mops = 0; start_trim_osc = 0;
      if (ready_osc) begin cnt_a++; if (first_t == 0) first_t = t; end
      if (end_trim_bus) cnt_b++;
      if (ready_osc != end_trim_bus) mism++;
    end
    check("trim_latency", 76'(first_t), 76'd65);
    check("trim_ready_cnt", 76'(cnt_a), 76'd1);
    check("trim_end_cnt", 76'(cnt_b), 76'd1);
    check("trim_coincide", 76'(mism), 76'd0);

    // RX phase, two buses.
    n_buses = 5'd1; test_rx = 1;
    frames = 0; bad_gaps = 0; last_t = 0; first_t = 0; cnt_a = 0; cnt_b = 0; t_a = 0;
    for (int t = 1; t <= 1200; t++) begin
      tick();
      test_rx = 0;
      if (test_rx_start) cnt_a++;
      if (test_rx_end) begin cnt_b++; t_a = t; end
      if (frame_valid) begin
        if (frames == 0) begin first_frame = bus_dec_data; first_t = t; end
        else if (t - last_t != 16) bad_gaps++;
        last_t = t; last_frame = bus_dec_data; frames++;
      end
    end
    check("rx_frames", 76'(frames), 76'd72);
    check("rx_gaps", 76'(bad_gaps), 76'd0);
    check("rx_first_t", 76'(first_t), 76'd2);
    check("rx_first_frame", first_frame,
          {5'd0, 11'h581, 4'h8, 8'h43, 16'h2400, 8'd0, 24'h0});
    check("rx_last_frame", last_frame,
          {5'd1, 11'h581, 4'h8, 8'h43, 16'h2400, 8'd35, 12'h0, 4'd1, 6'd35, 2'b00});
    check("rx_start_cnt", 76'(cnt_a), 76'd1);
    check("rx_end_cnt", 76'(cnt_b), 76'd1);
    check("rx_end_t", 76'(t_a), 76'd1154);
    check("rx_hold", bus_dec_data, last_frame);
    check("rx_no_err", 76'(tx_err), 76'd0);

    // TX phase, three buses, bus 1 never answered.
    n_buses = 5'd2; test_tx = 1;
    tx_frames = 0; cnt_a = 0; cnt_b = 0; t_a = 0; t_b = 0;
    for (int t = 1; t <= 1300; t++) begin
      tick();
      test_tx = 0;
      hub_step();
      if (test_tx_start) begin cnt_a++; if (bus_id == 8'd1) t_a = t; end
      if (test_tx_end) cnt_b++;
      if (tx_err && t_b == 0) t_b = t;
      if (frame_valid) begin
        if (tx_frames == 0) tx_frame0 = bus_dec_data; else tx_frame1 = bus_dec_data;
        tx_frames++;
      end
    end
    check("tx_frames", 76'(tx_frames), 76'd2);
    check("tx_frame_bus0", tx_frame0, {5'd0, 11'h581, 4'h8, 8'h60, 16'h2400, 8'd0, 24'h0});
    check("tx_frame_bus2", tx_frame1,
          {5'd2, 11'h581, 4'h8, 8'h60, 16'h2400, 8'd0, 12'h0, 4'd2, 6'd0, 2'b00});
    check("tx_start_cnt", 76'(cnt_a), 76'd3);
    check("tx_end_cnt", 76'(cnt_b), 76'd1);
    check("tx_err", 76'(tx_err), 76'd1);
    check("tx_timeout_t", 76'(t_b - t_a), 76'd1025);

    // Advanced phase held high: RX then TX, then immediate restart.
    n_buses = 5'd0; test_advanced = 1;
    frames = 0; tx_frames = 0; cnt_a = 0; t_a = 0; t_b = 0; t_c = 0; t_d = 0; done = 0;
    for (int t = 1; t <= 2000 && !done; t++) begin
      tick();
      hub_step();
      if (test_rx_end && t_a == 0) t_a = t;
      if (test_tx_start && t_b == 0) t_b = t;
      if (test_advanced_end) begin cnt_a++; t_c = t; end
      if (frame_valid && t_c == 0) begin
        if (bus_dec_data[55:48] == 8'h43) frames++; else tx_frames++;
      end
      if (test_rx_start && t > 1) begin t_d = t; done = 1; end
    end
    test_advanced = 0;
    check("adv_rx_frames", 76'(frames), 76'd36);
    check("adv_tx_frames", 76'(tx_frames), 76'd1);
    check("adv_rx_then_tx", 76'(t_b - t_a), 76'd1);
    check("adv_end_cnt", 76'(cnt_a), 76'd1);
    check("adv_restart", 76'(t_d - t_c), 76'd2);

    // Reset in the middle of the restarted phase's RX_RUN.
    repeat (40) begin tick(); hub_step(); end
    rst = 1'b0;
    tick();
    check("mid_rst_pulses", 76'(pulses()), 76'd0);
    check("mid_rst_frame", bus_dec_data, 76'd0);
    check("mid_rst_bus_ch", 76'({bus_id, adc_ch, clk_mops}), 76'd0);
    rst = 1'b1;
    pulse_or = '0;
    repeat (800) begin tick(); pulse_or |= pulses(); end
    check("post_rst_quiet", 76'(pulse_or), 76'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mops_data_generator.md
Name: mops_data_generator

Overview:
- Synthesizable stimulus and emulation block for MOPSHUB system test: emulates the MOPS front-end chips behind up to 32 CAN buses.
- Generates the divided MOPS clock and runs oscillator-trim handshakes.
- Sequences RX (ADC readout), TX (downlink acknowledge) and advanced (RX then TX) test phases, emitting decoded 76-bit CAN frames.
- Sits beside the hub core, driven by the top-level test controller.

Parameters:
- DIV_RATIO, 4, clk_mops = clk_40_m / DIV_RATIO; even, >=2.
- N_ADC_CH, 36, ADC channels read per bus in RX phase (1..63).
- FRAME_GAP, 16, clk_40_m cycles from one frame_valid to the next (>=2).
- TRIM_CYCLES, 64, cycles from trim start to ready_osc.
- TX_TIMEOUT, 1024, cycles to wait for a downlink frame per bus.

Ports:
- clk_40_m in 1: system clock.
- rst in 1: synchronous, active-low reset; clock clk_40_m.
- n_buses in 5: highest bus index exercised (0..31).
- ext_trim_mops in 1: trim request.
- start_trim_osc in 1: hub trim acknowledge.
- test_rx, test_tx, test_advanced in 1 each: level-sensitive phase requests.
- tra_valid in 1: downlink frame strobe from hub.
- can_tra_select in 5: bus index of the downlink frame.
- clk_mops out 1: divided clock.
- ready_osc out 1: trim-done pulse.
- end_trim_bus out 1: trim-done pulse.
- test_rx_start, test_rx_end, test_tx_start, test_tx_end, test_advanced_end out 1 each: 1-cycle pulses.
- bus_id out 8: current bus ({3'b0,bus}).
- adc_ch out 6: current channel.
- bus_dec_data out 76: emitted frame.
- frame_valid out 1: 1-cycle frame strobe.
- tx_err out 1: sticky timeout flag.

Behaviour:
- Reset (rst=0 at a clk_40_m edge): all outputs 0, FSM IDLE, counters 0; reset mid-phase aborts the phase with no end pulse.
- clk_mops: toggles every DIV_RATIO/2 clk_40_m cycles, starting at 0 after reset; 50% duty.
- Frame format:
  - [75:71] = bus index.
  - [70:60] = 11'h581.
  - [59:56] = 4'h8.
  - [55:48] = command byte: 8'h43 for RX, 8'h60 for TX.
  - [47:32] = 16'h2400.
  - [31:24] = {2'b0, adc_ch}.
  - [23:0] = {12'h0, bus[3:0], adc_ch, 2'b00}.
  - bus_dec_data holds its value until the next frame.
- FSM states: IDLE, TRIM, RX_START, RX_RUN, RX_END, TX_START, TX_WAIT, TX_END, ADV_END.
- IDLE: requests sampled only here. Priority: ext_trim_mops&start_trim_osc > test_advanced > test_rx > test_tx.
- TRIM: count TRIM_CYCLES, then pulse ready_osc and end_trim_bus together for 1 cycle; return to IDLE.
- RX_START: pulse test_rx_start; bus=0, ch=0.
- RX_RUN:
  - frame_valid pulses on the first RX_RUN cycle, then every FRAME_GAP cycles.
  - Channel increments 0..N_ADC_CH-1, then wraps to 0 and bus increments.
  - After frame for bus==n_buses, ch==N_ADC_CH-1, wait FRAME_GAP, go to RX_END.
- RX_END: pulse test_rx_end. Plain RX phase returns to IDLE; advanced mode goes to TX_START with bus=0.
- TX_START: pulse test_tx_start for the current bus; go to TX_WAIT.
- TX_WAIT:
  - On tra_valid with can_tra_select==bus: emit TX frame (adc_ch=0), go to the next bus.
  - After TX_TIMEOUT cycles: set tx_err, go to the next bus.
  - tra_valid with a mismatching select is ignored.
  - After bus n_buses, go to TX_END.
- TX_END: pulse test_tx_end. Advanced mode goes to ADV_END (pulse test_advanced_end), then IDLE.
- Return to IDLE: a still-asserted request restarts the phase on the next cycle (looping).
- n_buses=0: exactly one bus exercised.
- n_buses and the test requests are captured at phase start; changes mid-phase are ignored.
- tx_err: cleared only by reset.

Test Plan:
- Reset release, DIV_RATIO=4 -> clk_mops period 4 clk_40_m cycles; all pulses 0.
- ext_trim_mops=1, start_trim_osc=1 -> ready_osc and end_trim_bus high together exactly 1 cycle, TRIM_CYCLES+1 cycles later.
- n_buses=1, test_rx=1 one cycle:
  - 72 frame_valid pulses, FRAME_GAP apart.
  - First frame: bus 0, ch 0, [70:60]=0x581, [55:48]=0x43.
  - Last frame: bus 1, ch 35.
  - Exactly one test_rx_end pulse.
- n_buses=2, test_tx=1 one cycle, hub answers buses 0 and 2 only -> tx_err=1 after TX_TIMEOUT on bus 1; two frames with [55:48]=0x60; one test_tx_end pulse.
- test_advanced held high -> RX then TX sequence, one test_advanced_end pulse, then immediate restart.
- rst=0 during RX_RUN -> all outputs 0 next cycle; no test_rx_end pulse.
